// File: rtl/id_decode_control_pkg.sv
// Shared encodings for the ID-stage decoder: addressing modes, ALU opcodes,
// condition codes and the 48-bit ASCII mnemonic table.
package id_decode_control_pkg;

    localparam logic [1:0] AM_ROT_IMM   = 2'b00;
    localparam logic [1:0] AM_SHIFT_REG = 2'b01;
    localparam logic [1:0] AM_IMM_OFF   = 2'b10;
    localparam logic [1:0] AM_REG_OFF   = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [47:0] KW_NOP   = "NOP   ";
    localparam logic [47:0] KW_UNDEF = "UNDEF ";
    localparam logic [47:0] KW_LDR   = "LDR   ";
    localparam logic [47:0] KW_LDRB  = "LDRB  ";
    localparam logic [47:0] KW_STR   = "STR   ";
    localparam logic [47:0] KW_STRB  = "STRB  ";
    localparam logic [47:0] KW_B     = "B     ";
    localparam logic [47:0] KW_BL    = "BL    ";

    // Compare/test ops always set flags, so they never carry the S suffix.
    function automatic logic [47:0] dp_mnemonic(input logic [3:0] op, input logic s);
        logic [23:0] name;
        case (op)
            4'b0000: name = "AND";
            4'b0001: name = "EOR";
            4'b0010: name = "SUB";
            4'b0011: name = "RSB";
            4'b0100: name = "ADD";
            4'b0101: name = "ADC";
            4'b0110: name = "SBC";
            4'b0111: name = "RSC";
            4'b1000: name = "TST";
            4'b1001: name = "TEQ";
            4'b1010: name = "CMP";
            4'b1011: name = "CMN";
            4'b1100: name = "ORR";
            4'b1101: name = "MOV";
            4'b1110: name = "BIC";
            default: name = "MVN";
        endcase
        return {name, (s && op[3:2] != 2'b10) ? "S" : " ", "  "};
    endfunction

endpackage

// File: rtl/id_decode_control_cond_eval.sv
// Evaluates an ARM condition field against a {N,Z,C,V} flag set.
module id_decode_control_cond_eval
    import id_decode_control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);
    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = flags;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = w_z;
            COND_NE: cond_true = ~w_z;
            COND_CS: cond_true = w_c;
            COND_CC: cond_true = ~w_c;
            COND_MI: cond_true = w_n;
            COND_PL: cond_true = ~w_n;
            COND_VS: cond_true = w_v;
            COND_VC: cond_true = ~w_v;
            COND_HI: cond_true = w_c & ~w_z;
            COND_LS: cond_true = ~w_c | w_z;
            COND_GE: cond_true = (w_n == w_v);
            COND_LT: cond_true = (w_n != w_v);
            COND_GT: cond_true = ~w_z & (w_n == w_v);
            COND_LE: cond_true = w_z | (w_n != w_v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/id_decode_control.sv
// ID-stage control: combinational decode, hazard bubble mux, branch resolution
// and the PSR flag register feeding condition evaluation.
module id_decode_control
    import id_decode_control_pkg::*;
(
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] instruction,
    input  logic        nop_sel,
    input  logic        ex_s_enable,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  ID_opcode,
    output logic [1:0]  ID_AM,
    output logic        ID_S_enable,
    output logic        ID_load_instr,
    output logic        ID_RF_enable,
    output logic        ID_Size_enable,
    output logic        ID_RW_enable,
    output logic        ID_Enable_signal,
    output logic        ID_BL_instr,
    output logic        ID_B_instr,
    output logic [47:0] keyword,
    output logic        Branch,
    output logic        BranchL,
    output logic [3:0]  PSR_flags
);
    logic [3:0] r_psr;
    logic [3:0] w_opcode;
    logic [1:0] w_am;
    logic       w_s, w_load, w_rf, w_size, w_rw, w_en, w_bl, w_b;
    logic [47:0] w_keyword;
    logic [3:0] w_eval_flags;
    logic       w_cond_true;
    logic [2:0] w_cls;

    assign w_cls = instruction[27:25];

    always_comb begin
        w_opcode  = 4'b0000;
        w_am      = AM_ROT_IMM;
        w_s       = 1'b0;
        w_load    = 1'b0;
        w_rf      = 1'b0;
        w_size    = 1'b0;
        w_rw      = 1'b0;
        w_en      = 1'b0;
        w_bl      = 1'b0;
        w_b       = 1'b0;
        w_keyword = KW_UNDEF;
        // An all-zero word would otherwise decode as ANDEQ r0,r0,r0.
        if (instruction == 32'd0) begin
            w_keyword = KW_NOP;
        end else if (w_cls == 3'b001 || (w_cls == 3'b000 && !instruction[4])) begin
            w_opcode  = instruction[24:21];
            w_am      = (w_cls == 3'b001) ? AM_ROT_IMM : AM_SHIFT_REG;
            w_s       = instruction[20];
            w_rf      = (instruction[24:23] != 2'b10);
            w_keyword = dp_mnemonic(instruction[24:21], instruction[20]);
        end else if (w_cls == 3'b010 || w_cls == 3'b011) begin
            w_am     = (w_cls == 3'b010) ? AM_IMM_OFF : AM_REG_OFF;
            w_en     = 1'b1;
            w_load   = instruction[20];
            w_rf     = instruction[20];
            w_rw     = ~instruction[20];
            w_size   = ~instruction[22];
            w_opcode = instruction[23] ? OP_ADD : OP_SUB;
            if (instruction[20])
                w_keyword = instruction[22] ? KW_LDRB : KW_LDR;
            else
                w_keyword = instruction[22] ? KW_STRB : KW_STR;
        end else if (w_cls == 3'b101) begin
            w_bl      = instruction[24];
            w_b       = ~instruction[24];
            w_keyword = instruction[24] ? KW_BL : KW_B;
        end
    end

    always_comb begin
        ID_opcode        = w_opcode;
        ID_AM            = w_am;
        ID_S_enable      = w_s;
        ID_load_instr    = w_load;
        ID_RF_enable     = w_rf;
        ID_Size_enable   = w_size;
        ID_RW_enable     = w_rw;
        ID_Enable_signal = w_en;
        ID_BL_instr      = w_bl;
        ID_B_instr       = w_b;
        if (nop_sel) begin
            ID_opcode        = 4'b0000;
            ID_AM            = 2'b00;
            ID_S_enable      = 1'b0;
            ID_load_instr    = 1'b0;
            ID_RF_enable     = 1'b0;
            ID_Size_enable   = 1'b0;
            ID_RW_enable     = 1'b0;
            ID_Enable_signal = 1'b0;
            ID_BL_instr      = 1'b0;
            ID_B_instr       = 1'b0;
        end
    end

    assign keyword = w_keyword;

    // Bypass: a flag-setting op in EX is seen by this cycle's branch.
    assign w_eval_flags = ex_s_enable ? alu_flags : r_psr;

    id_decode_control_cond_eval u_cond_eval (
        .cond      (instruction[31:28]),
        .flags     (w_eval_flags),
        .cond_true (w_cond_true)
    );

    assign Branch  = w_cond_true & (w_b | w_bl);
    assign BranchL = w_cond_true & w_bl;

    always_ff @(posedge clk or negedge R) begin
        if (!R)
            r_psr <= 4'b0000;
        else if (ex_s_enable)
            r_psr <= alu_flags;
    end

    assign PSR_flags = r_psr;
endmodule

// File: tb/tb_id_decode_control.sv
// Directed bench for id_decode_control: decode vectors, bubble mux, branch
// conditions with bypass, and PSR load/hold/async reset.
module tb_id_decode_control;
    logic        clk = 1'b0;
    logic        R;
    logic [31:0] instruction;
    logic        nop_sel;
    logic        ex_s_enable;
    logic [3:0]  alu_flags;
    logic [3:0]  ID_opcode;
    logic [1:0]  ID_AM;
    logic        ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
    logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
    logic [47:0] keyword;
    logic        Branch, BranchL;
    logic [3:0]  PSR_flags;
    logic [13:0] w_ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_decode_control dut (
        .clk(clk), .R(R), .instruction(instruction), .nop_sel(nop_sel),
        .ex_s_enable(ex_s_enable), .alu_flags(alu_flags),
        .ID_opcode(ID_opcode), .ID_AM(ID_AM), .ID_S_enable(ID_S_enable),
        .ID_load_instr(ID_load_instr), .ID_RF_enable(ID_RF_enable),
        .ID_Size_enable(ID_Size_enable), .ID_RW_enable(ID_RW_enable),
        .ID_Enable_signal(ID_Enable_signal), .ID_BL_instr(ID_BL_instr),
        .ID_B_instr(ID_B_instr), .keyword(keyword), .Branch(Branch),
        .BranchL(BranchL), .PSR_flags(PSR_flags)
    );

    // {opcode, AM, S, load, RF, Size, RW, Enable, BL, B}
    assign w_ctl = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                    ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s ok: %h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] instr, input logic ns);
        instruction = instr;
        nop_sel     = ns;
        #1;
    endtask

    initial begin
        R = 1'b0; instruction = 32'd0; nop_sel = 1'b0;
        ex_s_enable = 1'b0; alu_flags = 4'b0000;
        #3;
        check("psr_reset", {44'd0, PSR_flags}, 48'h0);
        check("nop_ctl", {34'd0, w_ctl}, 48'h0);
        check("nop_kw", keyword, "NOP   ");
        @(negedge clk); R = 1'b1;

        apply(32'hE2921005, 1'b0);
        check("adds_ctl", {34'd0, w_ctl}, {34'd0, 14'b0100_00_1_0_1_0_0_0_0_0});
        check("adds_kw", keyword, "ADDS  ");

        apply(32'hE5D43008, 1'b0);
        check("ldrb_ctl", {34'd0, w_ctl}, {34'd0, 14'b0100_10_0_1_1_0_0_1_0_0});
        check("ldrb_kw", keyword, "LDRB  ");

        apply(32'hE5043004, 1'b0);
        check("str_ctl", {34'd0, w_ctl}, {34'd0, 14'b0010_10_0_0_0_1_1_1_0_0});
        check("str_kw", keyword, "STR   ");

        apply(32'hE3510000, 1'b0);
        check("cmp_ctl", {34'd0, w_ctl}, {34'd0, 14'b1010_00_1_0_0_0_0_0_0_0});
        check("cmp_kw", keyword, "CMP   ");
        apply(32'hE3510000, 1'b1);
        check("cmp_bubble_ctl", {34'd0, w_ctl}, 48'h0);
        check("cmp_bubble_kw", keyword, "CMP   ");

        apply(32'hE1A00001, 1'b0);
        check("mov_ctl", {34'd0, w_ctl}, {34'd0, 14'b1101_01_0_0_1_0_0_0_0_0});
        check("mov_kw", keyword, "MOV   ");

        apply(32'hE0000010, 1'b0);
        check("undef_ctl", {34'd0, w_ctl}, 48'h0);
        check("undef_kw", keyword, "UNDEF ");

        // PSR load, hold, asynchronous clear between edges
        @(negedge clk); ex_s_enable = 1'b1; alu_flags = 4'b1001;
        @(posedge clk); #1;
        check("psr_load", {44'd0, PSR_flags}, 48'h9);
        ex_s_enable = 1'b0; alu_flags = 4'b0110;
        @(posedge clk); #1;
        check("psr_hold", {44'd0, PSR_flags}, 48'h9);
        #2; R = 1'b0; #1;
        check("psr_async_clr", {44'd0, PSR_flags}, 48'h0);
        #1; R = 1'b1;

        // BLEQ with stored Z=1
        @(negedge clk); ex_s_enable = 1'b1; alu_flags = 4'b0100;
        @(posedge clk); #1;
        ex_s_enable = 1'b0; alu_flags = 4'b0000;
        apply(32'h0B000010, 1'b0);
        check("bleq_z1", {46'd0, Branch, BranchL}, 48'h3);
        check("bleq_kw", keyword, "BL    ");
        check("bleq_ctl", {34'd0, w_ctl}, {34'd0, 14'b0000_00_0_0_0_0_0_0_1_0});
        apply(32'h0B000010, 1'b1);
        check("bleq_bubble_branch", {46'd0, Branch, BranchL}, 48'h3);
        check("bleq_bubble_ctl", {34'd0, w_ctl}, 48'h0);

        R = 1'b0; #1; R = 1'b1;
        apply(32'h0B000010, 1'b0);
        check("bleq_z0", {46'd0, Branch, BranchL}, 48'h0);
        ex_s_enable = 1'b1; alu_flags = 4'b0100; #1;
        check("bleq_bypass", {46'd0, Branch, BranchL}, 48'h3);
        ex_s_enable = 1'b0; alu_flags = 4'b0000;

        apply(32'hEA000000, 1'b0);
        check("bal", {46'd0, Branch, BranchL}, 48'h2);
        check("bal_kw", keyword, "B     ");
        apply(32'hFA000000, 1'b0);
        check("b_never", {46'd0, Branch, BranchL}, 48'h0);

        // BGT via bypass: N=1,V=1,Z=0 taken; Z=1 not taken
        ex_s_enable = 1'b1; alu_flags = 4'b1001;
        apply(32'hCA000004, 1'b0);
        check("bgt_taken", {46'd0, Branch, BranchL}, 48'h2);
        alu_flags = 4'b1101; #1;
        check("bgt_not_taken", {46'd0, Branch, BranchL}, 48'h0);
        ex_s_enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_decode_control.md
# id_decode_control

Instruction-decode control block for the pipelined ARM-subset CPU, sitting in the ID stage. It combinationally decodes the IF/ID instruction into datapath control signals and an ASCII mnemonic. It can replace those signals with a bubble under hazard control, and it resolves conditional B/BL. It also owns the PSR flag register that the condition evaluation reads.

## Interface
- No parameters.
- clk  in  1  rising-edge clock (PSR only)
- R  in  1  asynchronous, active-low reset
- instruction  in  32  current IF/ID instruction
- nop_sel  in  1  hazard-unit bubble select; 1 forces all ID_* outputs to 0
- ex_s_enable  in  1  S-enable of the instruction now in EX
- alu_flags  in  4  live ALU flags {N,Z,C,V} from EX
- ID_opcode  out  4  ALU opcode
- ID_AM  out  2  shifter addressing mode
- ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr  out  1 each  control bits
- keyword  out  48  six ASCII chars, left-justified, space-padded mnemonic; not affected by nop_sel
- Branch  out  1  take branch (B or BL, condition true)
- BranchL  out  1  take BL (link write to R14)
- PSR_flags  out  4  stored {N,Z,C,V}

## Operation
- Decode (combinational, raw signals default 0):
  - instruction == 0: NOP. All raw signals 0. Keyword "NOP".
  - [27:25]=001, DP immediate: opcode=[24:21], AM=00, S=[20].
  - [27:25]=000 and [4]=0, DP shifted register: opcode=[24:21], AM=01, S=[20].
  - DP RF_enable is 1, except for opcodes 1000–1011 (TST, TEQ, CMP, CMN), where it is 0.
  - [27:25]=010 (immediate offset) gives AM=10. [27:25]=011 (register offset) gives AM=11.
  - For both load/store forms:
    - Enable_signal=1.
    - load_instr=[20]. RF_enable=[20]. RW_enable=~[20].
    - Size_enable=~[22] (1=word, 0=byte).
    - opcode=0100 if U=[23]=1, else 0010. S=0.
  - [27:25]=101: BL_instr=[24], B_instr=~[24]. All other raw signals 0.
  - Any other encoding is treated as NOP but with keyword "UNDEF".
- Mnemonics:
  - DP, by opcode 0000–1111: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
  - A suffix "S" is appended when S=1, except on TST, TEQ, CMP and CMN.
  - Load/store: LDR, LDRB, STR, STRB. Branch: B, BL.
- Bubble mux: nop_sel=1 drives every ID_* output to 0; nop_sel=0 passes the raw signals.
- Flag source: eval_flags = ex_s_enable ? alu_flags : PSR_flags.
- Condition on [31:28]:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V.
  - GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
- Branch = cond & (raw B_instr | raw BL_instr). BranchL = cond & raw BL_instr.
- Branch and BranchL use the pre-bubble decode, so nop_sel does not suppress them.

## Timing
- Decode, bubble mux, keyword, Branch and BranchL are combinational, with zero-cycle latency.
- PSR update: on a rising clk with ex_s_enable=1, PSR_flags <= alu_flags. Otherwise PSR_flags holds.
- Reset: R=0 clears PSR_flags to 0000 immediately, regardless of clk, including mid-operation. Combinational outputs follow their inputs and the reset PSR.
- Same-cycle bypass: a branch decoded while the flag-setting instruction is in EX sees the new flags in that cycle, before the PSR latches them.

## Structure
- Shared package holds:
  - AM encodings (AM_ROT_IMM=00, AM_SHIFT_REG=01, AM_IMM_OFF=10, AM_REG_OFF=11).
  - ALU opcode constants.
  - Condition-code constants.
  - A 48-bit mnemonic function/constant table.
- One natural sub-module: cond_eval (cond code + flags → true/false). Decoder, bubble mux and PSR stay in the top.

## Test plan
- ADDS r1,r2,#5 (0xE2921005) → opcode 0100, AM 00, S=1, RF=1, other bits 0, keyword "ADDS".
- LDRB r3,[r4,#8] (0xE5D43008) → load=1, RF=1, Enable=1, RW=0, Size=0, opcode 0100, AM 10, keyword "LDRB".
- STR r3,[r4,#-4] (0xE5043004) → RW=1, Enable=1, Size=1, RF=0, load=0, opcode 0010.
- CMP r1,#0 (0xE3510000) with nop_sel=0 → opcode 1010, S=1, RF=0. Same input with nop_sel=1 → all ID_* 0, keyword "CMP".
- BLEQ (0x0B000010):
  - PSR Z=1, ex_s_enable=0 → Branch=1, BranchL=1.
  - PSR Z=0 → both 0.
  - ex_s_enable=1 with alu_flags=0100 → both 1.
- B AL (0xEA000000) → Branch=1, BranchL=0.
- PSR sequence: R low → 0000; clock with ex_s_enable=1, alu_flags=1001 → 1001; clock with ex_s_enable=0 → holds; R low between edges → 0000 at once.
